// File: rtl/lcd_cmd_seq.sv
// Command sequencer for an ILI9341-class display: emits the init sequence or a
// filled-cell redraw as a command/data-tagged byte stream over valid/ready.
module lcd_cmd_seq #(
    parameter int CELL         = 10,
    parameter int DELAY_CYCLES = 1_200_000,
    parameter int XW           = 5,
    parameter int YW           = 5
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          init_cycle,
    input  logic          en_update,
    input  logic [XW-1:0] x_cell,
    input  logic [YW-1:0] y_cell,
    input  logic [15:0]   color,
    input  logic          byte_ready,
    output logic [7:0]    byte_out,
    output logic          dcx,
    output logic          byte_valid,
    output logic          cmd_done,
    output logic          busy
);
    // state    | meaning
    // IDLE     | waiting for init_cycle / en_update
    // SEND     | presenting byte_out until the transmitter accepts it
    // WAIT_DLY | post-reset / sleep-out settling, byte_valid low
    // DONE     | one-cycle cmd_done pulse
    // REARM    | waiting for both requests to drop
    typedef enum logic [2:0] {IDLE, SEND, WAIT_DLY, DONE, REARM} state_t;

    localparam int PIX_N   = CELL * CELL;
    localparam int PW      = $clog2(PIX_N + 1);
    localparam int DW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [3:0] PIX_IDX = 4'd11;

    state_t          state, state_nxt;
    logic            is_upd, is_upd_nxt;
    logic [3:0]      idx, idx_nxt;
    logic            half, half_nxt;
    logic [PW-1:0]   pix_cnt, pix_nxt;
    logic [DW-1:0]   dly_cnt, dly_nxt;
    logic [XW-1:0]   x_lat, x_nxt;
    logic [YW-1:0]   y_lat, y_nxt;
    logic [15:0]     color_lat, color_nxt;
    logic [8:0]      out_nxt;
    logic            valid_nxt, done_nxt, busy_nxt, last;
    logic [15:0]     xs, xe, ys, ye;

    assign xs = 16'(x_lat) * 16'(CELL);
    assign xe = xs + 16'(CELL - 1);
    assign ys = 16'(y_lat) * 16'(CELL);
    assign ye = ys + 16'(CELL - 1);

    // Returns {dcx, byte} for sequence position i; positions >= PIX_IDX are pixels.
    function automatic logic [8:0] seq_byte(input logic upd, input logic [3:0] i, input logic h,
                                            input logic [15:0] cxs, input logic [15:0] cxe,
                                            input logic [15:0] cys, input logic [15:0] cye,
                                            input logic [15:0] col);
        logic [8:0] r;
        r = 9'h000;
        if (!upd) begin
            case (i)
                4'd0:    r = {1'b0, 8'h01};
                4'd1:    r = {1'b0, 8'h11};
                4'd2:    r = {1'b0, 8'h3A};
                4'd3:    r = {1'b1, 8'h55};
                default: r = {1'b0, 8'h29};
            endcase
        end else begin
            case (i)
                4'd0:    r = {1'b0, 8'h2A};
                4'd1:    r = {1'b1, cxs[15:8]};
                4'd2:    r = {1'b1, cxs[7:0]};
                4'd3:    r = {1'b1, cxe[15:8]};
                4'd4:    r = {1'b1, cxe[7:0]};
                4'd5:    r = {1'b0, 8'h2B};
                4'd6:    r = {1'b1, cys[15:8]};
                4'd7:    r = {1'b1, cys[7:0]};
                4'd8:    r = {1'b1, cye[15:8]};
                4'd9:    r = {1'b1, cye[7:0]};
                4'd10:   r = {1'b0, 8'h2C};
                default: r = {1'b1, h ? col[7:0] : col[15:8]};
            endcase
        end
        return r;
    endfunction

    assign last = is_upd ? (idx == PIX_IDX && half && pix_cnt == PW'(PIX_N - 1))
                         : (idx == 4'd4);

    always_comb begin
        state_nxt  = state;
        is_upd_nxt = is_upd;
        idx_nxt    = idx;
        half_nxt   = half;
        pix_nxt    = pix_cnt;
        dly_nxt    = dly_cnt;
        x_nxt      = x_lat;
        y_nxt      = y_lat;
        color_nxt  = color_lat;
        out_nxt    = {dcx, byte_out};
        valid_nxt  = byte_valid;
        done_nxt   = 1'b0;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (init_cycle) begin
                    state_nxt  = SEND;
                    is_upd_nxt = 1'b0;
                    idx_nxt    = 4'd0;
                    out_nxt    = {1'b0, 8'h01};
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end else if (en_update) begin
                    state_nxt  = SEND;
                    is_upd_nxt = 1'b1;
                    idx_nxt    = 4'd0;
                    half_nxt   = 1'b0;
                    pix_nxt    = '0;
                    x_nxt      = x_cell;
                    y_nxt      = y_cell;
                    color_nxt  = color;
                    out_nxt    = {1'b0, 8'h2A};
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (last) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        if (is_upd && idx == PIX_IDX) begin
                            half_nxt = ~half;
                            if (half) pix_nxt = pix_cnt + PW'(1);
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                        out_nxt = seq_byte(is_upd, idx_nxt, half_nxt, xs, xe, ys, ye, color_lat);
                        // Software reset and sleep-out need settling time before the next byte.
                        if (!is_upd && idx <= 4'd1) begin
                            state_nxt = WAIT_DLY;
                            valid_nxt = 1'b0;
                            dly_nxt   = DW'(DELAY_CYCLES - 1);
                        end
                    end
                end
            end
            WAIT_DLY: begin
                if (dly_cnt == '0) begin
                    state_nxt = SEND;
                    valid_nxt = 1'b1;
                end else begin
                    dly_nxt = dly_cnt - DW'(1);
                end
            end
            DONE: begin
                state_nxt = REARM;
                busy_nxt  = 1'b0;
            end
            REARM: begin
                if (!init_cycle && !en_update) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            is_upd     <= 1'b0;
            idx        <= '0;
            half       <= 1'b0;
            pix_cnt    <= '0;
            dly_cnt    <= '0;
            x_lat      <= '0;
            y_lat      <= '0;
            color_lat  <= '0;
            byte_out   <= '0;
            dcx        <= 1'b0;
            byte_valid <= 1'b0;
            cmd_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            is_upd     <= is_upd_nxt;
            idx        <= idx_nxt;
            half       <= half_nxt;
            pix_cnt    <= pix_nxt;
            dly_cnt    <= dly_nxt;
            x_lat      <= x_nxt;
            y_lat      <= y_nxt;
            color_lat  <= color_nxt;
            byte_out   <= out_nxt[7:0];
            dcx        <= out_nxt[8];
            byte_valid <= valid_nxt;
            cmd_done   <= done_nxt;
            busy       <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: queue-based model of the expected byte stream, checked
// every cycle on the falling edge, plus literal sequences for the directed cases.
module tb_lcd_cmd_seq;
    localparam int CELL = 2;
    localparam int DLY  = 4;
    localparam int XW   = 5;
    localparam int YW   = 5;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          init_cycle = 1'b0;
    logic          en_update = 1'b0;
    logic [XW-1:0] x_cell = '0;
    logic [YW-1:0] y_cell = '0;
    logic [15:0]   color = '0;
    logic          byte_ready = 1'b0;
    logic [7:0]    byte_out;
    logic          dcx, byte_valid, cmd_done, busy;

    lcd_cmd_seq #(.CELL(CELL), .DELAY_CYCLES(DLY), .XW(XW), .YW(YW)) dut (
        .clk(clk), .nrst(nrst), .init_cycle(init_cycle), .en_update(en_update),
        .x_cell(x_cell), .y_cell(y_cell), .color(color), .byte_ready(byte_ready),
        .byte_out(byte_out), .dcx(dcx), .byte_valid(byte_valid),
        .cmd_done(cmd_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic wait_after; logic [8:0] db; } item_t;
    item_t      exp_q[$];
    logic [8:0] seen[$];
    int total = 0, bad = 0;
    int phase = 0;      // 0 idle, 1 running, 2 done pulse, 3 waiting for requests to drop
    int gap = 0;
    int n_done = 0;
    int rdy_mode = 0, stall_left = 0;

    task automatic push(input logic w, input logic d, input logic [7:0] b);
        item_t it;
        it.wait_after = w;
        it.db = {d, b};
        exp_q.push_back(it);
    endtask

    task automatic build_init();
        push(1'b1, 1'b0, 8'h01);
        push(1'b1, 1'b0, 8'h11);
        push(1'b0, 1'b0, 8'h3A);
        push(1'b0, 1'b1, 8'h55);
        push(1'b0, 1'b0, 8'h29);
    endtask

    task automatic build_upd(input int x, input int y, input logic [15:0] col);
        logic [15:0] xs, xe, ys, ye;
        xs = 16'((x * CELL) % 65536);
        xe = 16'((x * CELL + CELL - 1) % 65536);
        ys = 16'((y * CELL) % 65536);
        ye = 16'((y * CELL + CELL - 1) % 65536);
        push(1'b0, 1'b0, 8'h2A);
        push(1'b0, 1'b1, xs[15:8]); push(1'b0, 1'b1, xs[7:0]);
        push(1'b0, 1'b1, xe[15:8]); push(1'b0, 1'b1, xe[7:0]);
        push(1'b0, 1'b0, 8'h2B);
        push(1'b0, 1'b1, ys[15:8]); push(1'b0, 1'b1, ys[7:0]);
        push(1'b0, 1'b1, ye[15:8]); push(1'b0, 1'b1, ye[7:0]);
        push(1'b0, 1'b0, 8'h2C);
        for (int p = 0; p < CELL * CELL; p++) begin
            push(1'b0, 1'b1, col[15:8]);
            push(1'b0, 1'b1, col[7:0]);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so on the falling edge
    // the inputs seen here are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        logic [2:0] want_ctl;
        item_t it;
        if (!nrst) begin
            total++;
            if ({byte_out, dcx, byte_valid, cmd_done, busy} !== 12'h000) begin
                bad++;
                $display("FAIL reset_outputs got=%h want=000", {byte_out, dcx, byte_valid, cmd_done, busy});
            end
            phase = 0;
            gap = 0;
            exp_q.delete();
        end else begin
            want_ctl = {(phase == 1 || phase == 2), (phase == 1 && gap == 0), (phase == 2)};
            total++;
            if ({busy, byte_valid, cmd_done} !== want_ctl) begin
                bad++;
                $display("FAIL ctrl busy/valid/done got=%b want=%b t=%0t", {busy, byte_valid, cmd_done}, want_ctl, $time);
            end
            if (want_ctl[1] && byte_valid && exp_q.size() > 0) begin
                total++;
                if ({dcx, byte_out} !== exp_q[0].db) begin
                    bad++;
                    $display("FAIL byte dcx:byte got=%h want=%h t=%0t", {dcx, byte_out}, exp_q[0].db, $time);
                end
            end
            if (cmd_done) n_done++;
            if (byte_valid && byte_ready) seen.push_back({dcx, byte_out});
            case (phase)
                0: begin
                    if (init_cycle) begin build_init(); phase = 1; gap = 0; end
                    else if (en_update) begin build_upd(int'(x_cell), int'(y_cell), color); phase = 1; gap = 0; end
                end
                1: begin
                    if (gap > 0) gap--;
                    else if (byte_ready && exp_q.size() > 0) begin
                        it = exp_q.pop_front();
                        if (it.wait_after) gap = DLY;
                        if (exp_q.size() == 0) phase = 2;
                    end
                end
                2: phase = 3;
                default: if (!init_cycle && !en_update) phase = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: byte_ready = 1'b1;
            1: begin
                if (seen.size() == 3 && stall_left > 0) begin
                    byte_ready = 1'b0;
                    stall_left--;
                end else begin
                    byte_ready = ~byte_ready;
                end
            end
            default: byte_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic wait_done(input string name, input int max);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < max) begin
            step();
            k++;
        end
        total++;
        if (n_done == start) begin
            bad++;
            $display("FAIL %s_timeout done_pulses=%0d want=1", name, n_done - start);
        end
    endtask

    task automatic check_seen(input string name, input logic [8:0] want[$]);
        total++;
        if (seen.size() != want.size()) begin
            bad++;
            $display("FAIL %s_len got=%0d want=%0d", name, seen.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                total++;
                if (seen[i] !== want[i]) begin
                    bad++;
                    $display("FAIL %s_byte%0d got=%h want=%h", name, i, seen[i], want[i]);
                end
            end
        end
    endtask

    logic [8:0] want_init[$];
    logic [8:0] want_upd[$];

    initial begin
        int base;
        int k;
        want_init = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h029};
        want_upd  = '{9'h02A, 9'h100, 9'h106, 9'h100, 9'h107,
                      9'h02B, 9'h100, 9'h102, 9'h100, 9'h103, 9'h02C,
                      9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100};

        repeat (3) step();
        nrst = 1'b1;
        repeat (2) step();

        // init held high throughout; must not restart
        seen.delete();
        base = n_done;
        init_cycle = 1'b1;
        wait_done("init", 200);
        repeat (10) step();
        total++;
        if (n_done - base != 1) begin
            bad++;
            $display("FAIL init_done_count got=%0d want=1", n_done - base);
        end
        check_seen("init", want_init);
        init_cycle = 1'b0;
        repeat (3) step();

        // update, ready always high
        seen.delete();
        x_cell = 5'd3; y_cell = 5'd1; color = 16'hF800;
        en_update = 1'b1; step(); en_update = 1'b0;
        wait_done("upd", 200);
        check_seen("upd", want_upd);
        repeat (3) step();

        // same update with toggling ready and a stall on the 4th byte
        seen.delete();
        rdy_mode = 1; stall_left = 5; byte_ready = 1'b1;
        en_update = 1'b1; step(); en_update = 1'b0;
        wait_done("stall", 300);
        check_seen("stall", want_upd);
        rdy_mode = 0;
        repeat (3) step();

        // both requests: init wins; update only after both drop and en rises again
        seen.delete();
        init_cycle = 1'b1; en_update = 1'b1;
        wait_done("both", 200);
        check_seen("both", want_init);
        repeat (4) step();
        init_cycle = 1'b0;
        repeat (4) step();
        en_update = 1'b0;
        step();
        seen.delete();
        en_update = 1'b1; step(); en_update = 1'b0;
        wait_done("both_upd", 200);
        check_seen("both_upd", want_upd);
        repeat (3) step();

        // inputs changed after latch
        seen.delete();
        en_update = 1'b1; step(); en_update = 1'b0;
        repeat (3) step();
        x_cell = 5'd7; y_cell = 5'd9; color = 16'h1234;
        wait_done("latch", 200);
        check_seen("latch", want_upd);
        repeat (3) step();

        // reset during a pixel byte
        seen.delete();
        x_cell = 5'd5; y_cell = 5'd2; color = 16'hABCD;
        en_update = 1'b1; step(); en_update = 1'b0;
        k = 0;
        while (seen.size() < 13 && k < 100) begin step(); k++; end
        nrst = 1'b0;
        base = n_done;
        repeat (2) step();
        nrst = 1'b1;
        repeat (4) step();
        total++;
        if ({byte_out, dcx, n_done - base} !== {8'h00, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL post_reset got byte=%h dcx=%b dones=%0d want 00/0/0", byte_out, dcx, n_done - base);
        end
        en_update = 1'b1; step(); en_update = 1'b0;
        wait_done("after_reset", 200);
        repeat (3) step();

        // randomized sequences
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            logic hold;
            x_cell = XW'($urandom);
            y_cell = YW'($urandom);
            color  = 16'($urandom);
            hold   = 1'($urandom);
            if ($urandom_range(0, 4) == 0) init_cycle = 1'b1;
            else en_update = 1'b1;
            step();
            if (!hold) begin init_cycle = 1'b0; en_update = 1'b0; end
            repeat (3) step();
            x_cell = XW'($urandom);
            color  = 16'($urandom);
            if (hold && $urandom_range(0, 1) == 0) en_update = ~en_update;
            wait_done("rand", 400);
            init_cycle = 1'b0; en_update = 1'b0;
            repeat (3) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
- Command sequencer driven by the game control FSM. It receives that FSM's `init_cycle` / `en_update` requests and answers each with a `cmd_done` pulse.
- Produces the byte stream for an ILI9341-class display: the init sequence, or a filled-cell redraw at a cell coordinate.
- Bytes go to the downstream byte transmitter over a valid/ready handshake, each tagged command or data.

Parameters:
- CELL, 10, pixels per cell side.
- DELAY_CYCLES, 1_200_000, wait after software-reset and sleep-out commands.
- XW, 5, width of `x_cell`.
- YW, 5, width of `y_cell`.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- init_cycle  input  1  level request: run init sequence.
- en_update  input  1  level request: run cell update.
- x_cell  input  XW  cell column, latched at update start.
- y_cell  input  YW  cell row, latched at update start.
- color  input  16  RGB565 fill, latched at update start.
- byte_ready  input  1  transmitter accepts byte this cycle.
- byte_out  output  8  byte to transmit.
- dcx  output  1  0 = command, 1 = data.
- byte_valid  output  1  `byte_out` / `dcx` valid.
- cmd_done  output  1  one-cycle pulse when a sequence completes.
- busy  output  1  high from start through `cmd_done` cycle.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset is asynchronous and active-low on `nrst`.
  - All outputs are registered.
  - Reset values: `byte_out` = 0, `dcx` = 0, `byte_valid` = 0, `cmd_done` = 0, `busy` = 0; state IDLE; counters 0.
  - Reset mid-sequence aborts immediately. No partial `cmd_done` is issued.
- States: IDLE, SEND, WAIT_DLY, DONE, REARM.
- IDLE:
  - `init_cycle` high → start init. Priority: if both requests are high, `init_cycle` wins.
  - Else `en_update` high → start update and latch `x_cell`, `y_cell`, `color`.
  - `busy` rises the cycle after the start condition is sampled. The first `byte_valid` appears the same cycle.
- Init sequence, in order: cmd 0x01; WAIT_DLY; cmd 0x11; WAIT_DLY; cmd 0x3A; data 0x55; cmd 0x29.
- Update sequence, in order:
  - Coordinates: xs = `x_cell`·CELL, xe = xs+CELL−1, ys = `y_cell`·CELL, ye = ys+CELL−1. All are 16-bit with zero-extended operands; overflow wraps mod 2^16.
  - cmd 0x2A; data xs[15:8], xs[7:0], xe[15:8], xe[7:0].
  - cmd 0x2B; data ys[15:8], ys[7:0], ye[15:8], ye[7:0].
  - cmd 0x2C; then CELL·CELL pixels, each sent as data `color[15:8]` then `color[7:0]`.
- Handshake:
  - A transfer occurs on a rising edge with `byte_valid` & `byte_ready`.
  - While `byte_valid` is high and `byte_ready` is low, `byte_out` and `dcx` hold stable.
  - After a transfer, the next byte may be presented the following cycle (back-to-back allowed, 1 byte/cycle maximum).
  - `byte_valid` is never high in WAIT_DLY, DONE, REARM or IDLE.
  - `byte_valid` must not drop without a transfer.
- WAIT_DLY:
  - Entered after the 0x01 and 0x11 transfers.
  - Counts exactly DELAY_CYCLES cycles with `byte_valid` low, then resumes SEND.
- Completion:
  - After the last transfer, go to DONE. `cmd_done` = 1 for exactly one cycle, `busy` still 1.
  - Then REARM with `busy` = 0.
  - REARM returns to IDLE only once both requests are sampled low. This prevents a held request from restarting.
- Request changes while busy:
  - Requests are ignored (no restart, no truncation).
  - Request deassertion mid-sequence does not abort.
  - Input changes after the latch have no effect on the current update.
- Pixel counter: a pixel-count value of CELL·CELL must be representable; size the counter to at least $clog2(CELL·CELL+1) bits.

Test Plan:
- Reset, `init_cycle` = 1 held, `byte_ready` = 1, DELAY_CYCLES = 4 → bytes (dcx:byte) 0:01, 0:11, 0:3A, 1:55, 0:29.
  - 4 idle cycles follow each of 01 and 11.
  - Single `cmd_done` pulse after 29; no restart while `init_cycle` is held.
- CELL = 2, `x_cell` = 3, `y_cell` = 1, `color` = 0xF800, `en_update` pulse, `byte_ready` = 1 → 19 bytes: 0:2A, 1:00, 1:06, 1:00, 1:07, 0:2B, 1:00, 1:02, 1:00, 1:03, 0:2C, then 8 bytes alternating 1:F8, 1:00; `cmd_done` once.
- Same update with `byte_ready` toggling 1010… and a 5-cycle low stall on the 4th byte → identical byte sequence; `byte_out` / `dcx` stable during stalls; no duplicated or dropped bytes.
- `init_cycle` and `en_update` both high from IDLE → init sequence runs; update is not started until both requests drop and `en_update` rises again.
- `x_cell` / `color` changed mid-update → emitted coordinates and pixel bytes use the values latched at start.
- `nrst` asserted during a pixel byte, then released with no request → all outputs 0, no `cmd_done`; a new `en_update` runs a full correct sequence.
